// File: rtl/vae_bwd_pkg.sv
// ============================================================================
// Module  : vae_bwd_pkg
// Brief   : Shared Q8.8 constants, FSM states and saturation helpers for the
//           VAE decoder backward/SGD engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vae_bwd_pkg;

    localparam int                 FRAC_BITS = 8;
    localparam logic signed [15:0] Q_ONE     = 16'sh0100;
    localparam logic signed [15:0] Q_MAX     = 16'sh7FFF;
    localparam logic signed [15:0] Q_MIN     = 16'sh8000;
    localparam logic signed [15:0] Q_CLIP    = 16'sh0100;
    localparam logic signed [15:0] Q_NCLIP   = 16'shFF00;

    localparam int N_OUT = 9;
    localparam int N_LAT = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DELTA = 3'd2,
        WGRAD = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic signed [15:0] sat17(input logic signed [16:0] v);
        if (v > 17'sd32767)
            return Q_MAX;
        else if (v < -17'sd32768)
            return Q_MIN;
        else
            return v[15:0];
    endfunction

    function automatic logic signed [15:0] add_sat(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic signed [16:0] v;
        v = {a[15], a} + {b[15], b};
        return sat17(v);
    endfunction

    function automatic logic signed [15:0] sub_sat(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic signed [16:0] v;
        v = {a[15], a} - {b[15], b};
        return sat17(v);
    endfunction

    function automatic logic signed [15:0] clip_q(input logic signed [15:0] v);
        if (v > Q_CLIP)
            return Q_CLIP;
        else if (v < Q_NCLIP)
            return Q_NCLIP;
        else
            return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/top_level_backward_qmul.sv
// ============================================================================
// Module  : qmul_sat
// Brief   : Combinational signed Q8.8 multiply, arithmetic shift, saturation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module qmul_sat
    import vae_bwd_pkg::*;
(
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic signed [15:0] o_p
);

    logic signed [31:0] w_prod;
    logic signed [31:0] w_shr;

    assign w_prod = i_a * i_b;
    assign w_shr  = w_prod >>> FRAC_BITS;

    always_comb begin
        o_p = w_shr[15:0];
        if (w_shr > 32'sd32767)
            o_p = Q_MAX;
        else if (w_shr < -32'sd32768)
            o_p = Q_MIN;
    end

endmodule

`default_nettype wire

// File: rtl/top_level_backward.sv
// ============================================================================
// Module  : top_level_backward
// Brief   : Sequential backward pass + SGD update for the VAE decoder layer
//           (2 latents -> 9 sigmoid outputs). Optional macro GRAD_CLIP_EN
//           clamps deltas and weight gradients to +/-1.0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module top_level_backward
    import vae_bwd_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [16*N_OUT-1:0]       x_bus,
    input  logic [16*N_OUT-1:0]       out_bus,
    input  logic [16*N_LAT-1:0]       a2_bus,
    input  logic [16*N_OUT*N_LAT-1:0] w_bus,
    input  logic [16*N_OUT-1:0]       b_bus,
    input  logic [15:0]               lr,
    output logic                      busy,
    output logic                      done,
    output logic [16*N_OUT*N_LAT-1:0] w_new_bus,
    output logic [16*N_OUT-1:0]       b_new_bus,
    output logic [16*N_LAT-1:0]       dlat_bus
);

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0] r_i;
    logic       r_j;

    logic signed [15:0] r_x     [0:N_OUT-1];
    logic signed [15:0] r_out   [0:N_OUT-1];
    logic signed [15:0] r_b     [0:N_OUT-1];
    logic signed [15:0] r_delta [0:N_OUT-1];
    logic signed [15:0] r_b_wk  [0:N_OUT-1];
    logic signed [15:0] r_w     [0:2*N_OUT-1];
    logic signed [15:0] r_w_wk  [0:2*N_OUT-1];
    logic signed [15:0] r_a2    [0:N_LAT-1];
    logic signed [15:0] r_acc   [0:N_LAT-1];
    logic signed [15:0] r_lr;

    logic [16*N_OUT*N_LAT-1:0] r_w_new;
    logic [16*N_OUT-1:0]       r_b_new;
    logic [16*N_LAT-1:0]       r_dlat;

    logic [4:0]         w_k;
    logic               w_last_delta;
    logic               w_last;
    logic signed [15:0] w_delta_raw;
    logic signed [15:0] w_delta;
    logic signed [15:0] w_dcur;
    logic signed [15:0] w_dw_raw;
    logic signed [15:0] w_dw;
    logic signed [15:0] w_lr_op;
    logic signed [15:0] w_lr_prod;
    logic signed [15:0] w_g;
    logic signed [15:0] w_b_nxt;
    logic signed [15:0] w_w_nxt;
    logic signed [15:0] w_acc_nxt;

    // Flat weight index: w_bus order w11,w12,w21,... gives k = 2*i + j.
    assign w_k          = {r_i, r_j};
    assign w_last_delta = (r_i == 4'(N_OUT - 1));
    assign w_last       = w_last_delta && r_j;

    assign w_delta_raw = sub_sat(r_out[r_i], r_x[r_i]);
    assign w_dcur      = r_delta[r_i];

`ifdef GRAD_CLIP_EN
    assign w_delta = clip_q(w_delta_raw);
    assign w_dw    = clip_q(w_dw_raw);
`else
    assign w_delta = w_delta_raw;
    assign w_dw    = w_dw_raw;
`endif

    // The lr multiplier serves the bias update in DELTA and the weight update in WGRAD.
    assign w_lr_op = (r_state == DELTA) ? w_delta : w_dw;

    qmul_sat u_mul_dw (
        .i_a (w_dcur),
        .i_b (r_a2[r_j]),
        .o_p (w_dw_raw)
    );

    qmul_sat u_mul_lr (
        .i_a (r_lr),
        .i_b (w_lr_op),
        .o_p (w_lr_prod)
    );

    qmul_sat u_mul_g (
        .i_a (w_dcur),
        .i_b (r_w[w_k]),
        .o_p (w_g)
    );

    assign w_b_nxt   = sub_sat(r_b[r_i], w_lr_prod);
    assign w_w_nxt   = sub_sat(r_w[w_k], w_lr_prod);
    assign w_acc_nxt = add_sat(r_acc[r_j], w_g);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = DELTA;
            DELTA:   if (w_last_delta) w_state_nxt = WGRAD;
            WGRAD:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_i     <= 4'd0;
            r_j     <= 1'b0;
            r_acc   <= '{default: '0};
            r_w_new <= '0;
            r_b_new <= '0;
            r_dlat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                LOAD: begin
                    r_i   <= 4'd0;
                    r_j   <= 1'b0;
                    r_acc <= '{default: '0};
                end
                DELTA: begin
                    r_i <= w_last_delta ? 4'd0 : r_i + 4'd1;
                    r_j <= 1'b0;
                end
                WGRAD: begin
                    r_acc[r_j] <= w_acc_nxt;
                    r_j        <= ~r_j;
                    if (r_j)
                        r_i <= r_i + 4'd1;
                    // Publish on the final step, merging the values computed this cycle.
                    if (w_last) begin
                        for (int n = 0; n < 2*N_OUT - 1; n++)
                            r_w_new[16*n +: 16] <= r_w_wk[n];
                        r_w_new[16*(2*N_OUT-1) +: 16] <= w_w_nxt;
                        for (int n = 0; n < N_OUT; n++)
                            r_b_new[16*n +: 16] <= r_b_wk[n];
                        r_dlat[15:0]  <= r_acc[0];
                        r_dlat[31:16] <= w_acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            for (int n = 0; n < N_OUT; n++) begin
                r_x[n]   <= x_bus[16*n +: 16];
                r_out[n] <= out_bus[16*n +: 16];
                r_b[n]   <= b_bus[16*n +: 16];
            end
            for (int n = 0; n < 2*N_OUT; n++)
                r_w[n] <= w_bus[16*n +: 16];
            for (int n = 0; n < N_LAT; n++)
                r_a2[n] <= a2_bus[16*n +: 16];
            r_lr <= lr;
        end
        if (r_state == DELTA) begin
            r_delta[r_i] <= w_delta;
            r_b_wk[r_i]  <= w_b_nxt;
        end
        if (r_state == WGRAD)
            r_w_wk[w_k] <= w_w_nxt;
    end

    assign busy      = (r_state == LOAD) || (r_state == DELTA) || (r_state == WGRAD);
    assign done      = (r_state == DONE);
    assign w_new_bus = r_w_new;
    assign b_new_bus = r_b_new;
    assign dlat_bus  = r_dlat;

endmodule

`default_nettype wire
